regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Sequencer and write-port arbiter for the 32x32 integer register file.
- After reset, walks every register index and writes zero through the single write port (INIT phase).
- Then shares that write port between two writeback requesters: A = ALU/execute result, B = load-return path.
- Uses round-robin arbitration with valid/ready handshakes.
- Sits between the writeback stage and the register file's write1/write_data/regwrite inputs.

Parameters:
WORDSIZE, 32, data width of a register (from defs.v)
REG_NUM, 32, number of architectural registers (from defs.v)
ADDR_W, 5, register index width; REG_NUM must equal 2**ADDR_W

Ports:
CLK  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-low reset
a_valid  input  1  requester A (ALU) has a write pending
a_ready  output  1  A's write accepted this cycle (combinational)
a_addr  input  ADDR_W  A destination register
a_data  input  WORDSIZE  A write data
b_valid  input  1  requester B (load) has a write pending
b_ready  output  1  B's write accepted this cycle (combinational)
b_addr  input  ADDR_W  B destination register
b_data  input  WORDSIZE  B write data
init_done  output  1  register file clear complete; high in RUN
rf_write1  output  ADDR_W  register file write index (registered)
rf_write_data  output  WORDSIZE  register file write data (registered)
rf_regwrite  output  1  register file write enable (registered)

Behaviour:
Reset:
- reset sampled low at posedge: state<=INIT, ctr<=0, last_grant<=B (A wins first tie).
- Outputs on that edge: rf_regwrite<=0, rf_write1<=0, rf_write_data<=0, init_done<=0.
- Reset low at any time, including mid-INIT or mid-RUN, restarts INIT from index 0. Accepted-but-unwritten data is discarded.

INIT:
- a_ready=b_ready=0.
- Each posedge: rf_write1<=ctr, rf_write_data<=0, rf_regwrite<=1, ctr<=ctr+1.
- When ctr==REG_NUM-1: state<=RUN, init_done<=1 on the same edge.
- Result: exactly REG_NUM consecutive write cycles for indices 0..31, in order.

RUN:
- Ready logic: only a_valid -> a_ready=1; only b_valid -> b_ready=1; both -> grant the requester that is not last_grant. Never both ready.
- Transfer = valid & ready. On a transfer edge: last_grant<=winner, rf_write1<=winner addr, rf_write_data<=winner data, rf_regwrite<=(winner addr!=0).
- Writes to x0 complete the handshake and update last_grant, but are never issued (rf_regwrite=0).
- No transfer: rf_regwrite<=0; rf_write1/rf_write_data hold their values.
- Latency: transfer at edge N -> rf_regwrite high during cycle N+1 -> register file updated at edge N+2.
- Fairness: with both valid continuously, grants alternate every cycle; no requester waits more than 1 cycle.
- Requesters hold valid/addr/data stable until ready. The arbiter adds no buffering, so throughput is 1 write/cycle.
- Same-address writes from A and B are ordered by grant order; the later grant wins in the register file.

Decomposition:
- defs.v supplies WORDSIZE and REG_NUM.
- State encoding (INIT=1'b0, RUN=1'b1) and requester ids (REQ_A=0, REQ_B=1) go in a shared header, wb_defs.v, for reuse by future writeback ports.
- One natural sub-module: rr_arb2, a two-way round-robin grant with a last_grant register and an update-on-transfer input.

Test Plan:
- Release reset -> rf_regwrite high for 32 consecutive cycles, rf_write1 = 0,1,...,31, data 0; init_done rises with the index-31 write; a_ready=0 throughout even with a_valid=1.
- RUN: a_valid=1, a_addr=5, a_data=0xDEADBEEF -> a_ready=1 the same cycle; next cycle rf_regwrite=1, rf_write1=5, rf_write_data=0xDEADBEEF; read port shows the value 2 edges after the transfer.
- Both valid for 4 cycles (A addr 1 / B addr 2) -> grants A,B,A,B; rf_write1 sequence 1,2,1,2.
- b_valid=1, b_addr=0, b_data=0x12345678 -> b_ready=1, rf_regwrite stays 0; a subsequent tie is granted to A.
- reset low at INIT index 10, released -> write walk restarts at index 0, 32 writes total, init_done low until complete.
- reset low in RUN with A pending -> next edge rf_regwrite=0, init_done=0, a_ready=0; INIT re-runs.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Provides default data/index widths, the sequencer state encoding and the
// requester ids. Future writeback ports reuse these.
package regfile_wb_arbiter_pkg;

  localparam int DEF_WORDSIZE = 32;
  localparam int DEF_REG_NUM  = 32;
  localparam int DEF_ADDR_W   = 5;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant.
// Ports:
//   i_clk      clock, state updates on posedge
//   i_rst_n    synchronous active-low reset (last grant -> B, so A wins first tie)
//   i_en       grants allowed (low during register-file clear)
//   i_req_a/b  request lines
//   i_update   a transfer happened this cycle; remember the winner
//   o_gnt_a/b  combinational grants, never both high
module regfile_wb_arbiter_rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_update,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  req_e r_last_grant;

  // On a tie the requester that did not win last time is served.
  assign o_gnt_a = i_en & i_req_a & (~i_req_b | (r_last_grant == REQ_B));
  assign o_gnt_b = i_en & i_req_b & (~i_req_a | (r_last_grant == REQ_A));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last_grant <= REQ_B;
    end else if (i_update) begin
      r_last_grant <= o_gnt_b ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port sequencer and writeback arbiter.
// After reset it clears every register through the single write port, then
// shares that port between the ALU result (A) and the load-return path (B).
// Ports:
//   CLK                 clock, all state updates on posedge
//   reset               synchronous active-low reset; restarts the clear walk
//   a_valid/a_addr/a_data, a_ready   requester A handshake (ready is combinational)
//   b_valid/b_addr/b_data, b_ready   requester B handshake (ready is combinational)
//   init_done           high once the clear walk has finished (RUN)
//   rf_write1/rf_write_data/rf_regwrite   registered register-file write port
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | writing zero to index r_ctr each cycle, requesters held off
// ST_RUN  | round-robin arbitration between A and B, one write per cycle
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int WORDSIZE = DEF_WORDSIZE,
  parameter int REG_NUM  = DEF_REG_NUM,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [WORDSIZE-1:0] a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [WORDSIZE-1:0] b_data,
  output logic                init_done,
  output logic [ADDR_W-1:0]   rf_write1,
  output logic [WORDSIZE-1:0] rf_write_data,
  output logic                rf_regwrite
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_ctr;
  logic [ADDR_W-1:0]   r_write1;
  logic [WORDSIZE-1:0] r_write_data;
  logic                r_regwrite;

  logic                w_run;
  logic                w_gnt_a;
  logic                w_gnt_b;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [WORDSIZE-1:0] w_win_data;

  assign w_run = (r_state == ST_RUN);

  regfile_wb_arbiter_rr_arb2 u_arb (
    .i_clk    (CLK),
    .i_rst_n  (reset),
    .i_en     (w_run),
    .i_req_a  (a_valid),
    .i_req_b  (b_valid),
    .i_update (w_xfer),
    .o_gnt_a  (w_gnt_a),
    .o_gnt_b  (w_gnt_b)
  );

  // Grants already include valid, so either grant is a transfer.
  assign w_xfer     = w_gnt_a | w_gnt_b;
  assign w_win_addr = w_gnt_b ? b_addr : a_addr;
  assign w_win_data = w_gnt_b ? b_data : a_data;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_ctr == LAST_IDX) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_state      <= ST_INIT;
      r_ctr        <= '0;
      r_write1     <= '0;
      r_write_data <= '0;
      r_regwrite   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_write1     <= r_ctr;
        r_write_data <= '0;
        r_regwrite   <= 1'b1;
        r_ctr        <= r_ctr + 1'b1;
      end else if (w_xfer) begin
        // x0 is hardwired zero: the handshake completes but nothing is written.
        r_write1     <= w_win_addr;
        r_write_data <= w_win_data;
        r_regwrite   <= (w_win_addr != '0);
      end else begin
        r_regwrite <= 1'b0;
      end
    end
  end

  // RUN is entered on the same edge that issues the last clear write.
  assign init_done     = w_run;
  assign a_ready       = w_gnt_a;
  assign b_ready       = w_gnt_b;
  assign rf_write1     = r_write1;
  assign rf_write_data = r_write_data;
  assign rf_regwrite   = r_regwrite;

endmodule
